// File: rtl/nice_adc_pkg.sv
// nice_adc_pkg: shared constants and types for the ADC data-out frame writer and reader.
package nice_adc_pkg;
  localparam int ADC_DATA_WIDTH = 24;
  localparam int ADC_N_CH = 2;
  localparam int ADC_FRAME_BITS = ADC_DATA_WIDTH * ADC_N_CH;
  typedef logic signed [ADC_DATA_WIDTH-1:0] adc_sample_t;
  typedef enum logic [1:0] {IDLE, DRDY, SHIFT, GAP} dout_state_t;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/dout_writer_dclk_timer.sv
// dclk_timer: half-period phase counter that toggles dclk while enabled and flags the falling toggle.
module dclk_timer #(
  parameter int DIV = 4,
  parameter int PW = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic dclk,
  output logic fall
);
  logic [PW-1:0] cnt;
  logic tick;
  assign tick = en && (cnt == PW'(DIV - 1));
  assign fall = tick && dclk;
  always_ff @(posedge clk)
    if (rst || !en) begin
      cnt  <= '0;
      dclk <= 1'b0;
    end else begin
      cnt  <= tick ? '0 : cnt + 1'b1;
      dclk <= dclk ^ tick;
    end
endmodule

// File: rtl/dout_writer.sv
// dout_writer: sends one {ch1, ch2} frame MSB first on drdy/dclk/dout, receiver samples on dclk rise.
module dout_writer
  import nice_adc_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int N_CH = ADC_N_CH,
  parameter int CLK_DIV = 4,
  parameter int DRDY_CYCLES = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic signed [DATA_WIDTH-1:0] ch1_i,
  input  logic signed [DATA_WIDTH-1:0] ch2_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic                         drdy_o,
  output logic                         dclk_o,
  output logic                         dout_o,
  output logic                         done_o
);
  localparam int FB = N_CH * DATA_WIDTH;
  localparam int BW = $clog2(FB);
  localparam int PM = $clog2(max3(CLK_DIV, DRDY_CYCLES, GAP_CYCLES));
  localparam int PW = (PM < 1) ? 1 : PM;
  dout_state_t   state;
  logic [FB-1:0] sr;
  logic [BW-1:0] bcnt;
  logic [PW-1:0] wcnt;
  logic          fall;
  dclk_timer #(.DIV(CLK_DIV), .PW(PW)) u_timer (
    .clk (clk_i),
    .rst (reset_i),
    .en  (state == SHIFT),
    .dclk(dclk_o),
    .fall(fall)
  );
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      drdy_o  <= 1'b1;
      dout_o  <= 1'b0;
      done_o  <= 1'b0;
      sr      <= '0;
      bcnt    <= '0;
      wcnt    <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE:
          if (valid_i && ready_o) begin
            state   <= DRDY;
            ready_o <= 1'b0;
            drdy_o  <= 1'b0;
            sr      <= FB'({ch1_i, ch2_i});
            dout_o  <= ch1_i[DATA_WIDTH-1];
            bcnt    <= '0;
            wcnt    <= '0;
          end
        DRDY:
          if (wcnt == PW'(DRDY_CYCLES - 1)) state <= SHIFT;
          else wcnt <= wcnt + 1'b1;
        SHIFT:
          // the next bit is presented on each dclk fall, so it is stable across the following rise
          if (fall) begin
            if (bcnt == BW'(FB - 1)) begin
              state  <= GAP;
              drdy_o <= 1'b1;
              dout_o <= 1'b0;
              wcnt   <= '0;
            end else begin
              bcnt   <= bcnt + 1'b1;
              sr     <= sr << 1;
              dout_o <= sr[FB-2];
            end
          end
        GAP:
          if (wcnt == PW'(GAP_CYCLES - 1)) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            done_o  <= 1'b1;
          end else wcnt <= wcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule
